// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam logic [7:0]  LOADER_HDR  = 8'hA5;
  localparam int unsigned INSTR_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage : imem_loader_pkg

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream (A5, N, N big-endian words, XOR
// checksum) and writes the words into instruction memory from address 0,
// keeping the CPU held in reset until a frame with a good checksum lands.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    words
);

  // Memory depth, held in 9 bits so it can be compared directly with N.
  localparam logic [8:0] DEPTH = 9'(2 ** ADDR_W);

  loader_state_e      state_q, state_d;
  logic               byte_ready_q, byte_ready_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [ADDR_W:0]    words_q, words_d;
  logic [7:0]         n_q, n_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         hi_q, hi_d;

  logic               hs;
  logic [ADDR_W:0]    words_inc;

  assign hs        = byte_valid && byte_ready_q;
  assign words_inc = words_q + (ADDR_W + 1)'(1);

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    error_d = error_q;
    words_d = words_q;
    n_d     = n_q;
    csum_d  = csum_q;
    hi_d    = hi_q;

    // Address moves on once the strobe cycle has been seen by the memory,
    // so addr/data stay stable for the whole write cycle.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          done_d  = 1'b0;
          error_d = 1'b0;
          words_d = '0;
          addr_d  = '0;
          hold_d  = 1'b1;
        end
      end
      ST_HDR: begin
        if (hs) begin
          if (byte_in == LOADER_HDR) begin
            state_d = ST_LEN;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_LEN: begin
        if (hs) begin
          n_d    = byte_in;
          csum_d = '0;
          if ({1'b0, byte_in} > DEPTH) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else if (byte_in == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (hs) begin
          hi_d    = byte_in;
          csum_d  = csum_q ^ byte_in;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (hs) begin
          we_d    = 1'b1;
          wdata_d = INSTR_W'({hi_q, byte_in});
          csum_d  = csum_q ^ byte_in;
          words_d = words_inc;
          state_d = (9'(words_inc) < {1'b0, n_q}) ? ST_HI : ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (hs) begin
          if (byte_in == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    byte_ready_d = (state_d == ST_HDR) || (state_d == ST_LEN) ||
                   (state_d == ST_HI)  || (state_d == ST_LO)  ||
                   (state_d == ST_CSUM);
  end

  // State and registered outputs; reset drops any pending write and holds the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_q      <= '0;
      n_q          <= '0;
      csum_q       <= '0;
      hi_q         <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_q      <= words_d;
      n_q          <= n_d;
      csum_q       <= csum_d;
      hi_q         <= hi_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words      = words_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_hold;
  logic               done;
  logic               error;
  logic [ADDR_W:0]    words;

  imem_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .words      (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned strobe_cyc[$];
  int unsigned cyc;
  int          strobes;
  int          errors;
  int          checks;

  initial begin
    cyc     = 0;
    strobes = 0;
    errors  = 0;
    checks  = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (imem_we === 1'b1) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      check("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("imem_addr", 32'(imem_addr), 32'(e.addr));
        check("imem_wdata", 32'(imem_wdata), 32'(e.data));
      end
    end
  end

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Offer a byte and wait (bounded) for it to be accepted; valid stays high.
  task automatic send_byte(input logic [7:0] b);
    bit hs;
    hs         = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = byte_ready;
      @(posedge clk);
      #1;
    end
    check("handshake", 32'(hs), 32'd1);
  endtask

  task automatic gap();
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_hold"},  32'(cpu_hold),   32'd1);
    check({p, "_done"},  32'(done),       32'd0);
    check({p, "_error"}, 32'(error),      32'd0);
    check({p, "_ready"}, 32'(byte_ready), 32'd0);
    check({p, "_we"},    32'(imem_we),    32'd0);
    check({p, "_addr"},  32'(imem_addr),  32'd0);
    check({p, "_wdata"}, 32'(imem_wdata), 32'd0);
    check({p, "_words"}, 32'(words),      32'd0);
  endtask

  initial begin
    int s0;
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good two-word frame, valid held high.
    push_wr(8'd0, 16'h1234);
    push_wr(8'd1, 16'hABCD);
    pulse_start();
    check("ready_after_start", 32'(byte_ready), 32'd1);
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h40);
    byte_valid = 1'b0;
    check("f1_done",  32'(done),     32'd1);
    check("f1_hold",  32'(cpu_hold), 32'd0);
    check("f1_error", 32'(error),    32'd0);
    check("f1_words", 32'(words),    32'd2);
    check("f1_addr",  32'(imem_addr), 32'd2);
    check("f1_ready", 32'(byte_ready), 32'd0);
    n = strobe_cyc.size();
    check("f1_strobes", 32'(strobes), 32'd2);
    if (n >= 2) check("f1_spacing", strobe_cyc[n-1] - strobe_cyc[n-2], 32'd2);
    @(posedge clk); #1;

    // Same frame, bad checksum: words land, frame rejected.
    pulse_start();
    check("restart_done",  32'(done),      32'd0);
    check("restart_words", 32'(words),     32'd0);
    check("restart_addr",  32'(imem_addr), 32'd0);
    check("restart_hold",  32'(cpu_hold),  32'd1);
    push_wr(8'd0, 16'h1234);
    push_wr(8'd1, 16'hABCD);
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h41);
    byte_valid = 1'b0;
    check("f2_error", 32'(error),    32'd1);
    check("f2_done",  32'(done),     32'd0);
    check("f2_hold",  32'(cpu_hold), 32'd1);
    check("f2_words", 32'(words),    32'd2);
    @(posedge clk); #1;

    // Bad header.
    s0 = strobes;
    pulse_start();
    check("f3_error_clr", 32'(error), 32'd0);
    send_byte(8'h5A);
    byte_valid = 1'b0;
    check("f3_error", 32'(error),      32'd1);
    check("f3_ready", 32'(byte_ready), 32'd0);
    check("f3_words", 32'(words),      32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("f3_no_we", 32'(strobes), 32'(s0));

    // Empty frame.
    pulse_start();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    check("f4_done",  32'(done),     32'd1);
    check("f4_hold",  32'(cpu_hold), 32'd0);
    check("f4_words", 32'(words),    32'd0);
    check("f4_no_we", 32'(strobes),  32'(s0));
    @(posedge clk); #1;

    // Three words with valid toggling every other cycle.
    s0 = strobes;
    push_wr(8'd0, 16'hDEAD);
    push_wr(8'd1, 16'hBEEF);
    push_wr(8'd2, 16'h0102);
    pulse_start();
    send_byte(8'hA5); gap(); send_byte(8'h03); gap();
    send_byte(8'hDE); gap(); send_byte(8'hAD); gap();
    send_byte(8'hBE); gap(); send_byte(8'hEF); gap();
    send_byte(8'h01); gap(); send_byte(8'h02); gap();
    send_byte(8'h21); gap();
    check("f5_done",    32'(done),      32'd1);
    check("f5_words",   32'(words),     32'd3);
    check("f5_addr",    32'(imem_addr), 32'd3);
    check("f5_strobes", 32'(strobes - s0), 32'd3);

    // Reset between HI and LO of the second word.
    push_wr(8'd0, 16'h1234);
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    s0 = strobes;
    #1;
    check_reset("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("midrst_hold");
    check("midrst_no_we", 32'(strobes), 32'(s0));
    check("midrst_q", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reload after reset starts at address 0.
    push_wr(8'd0, 16'h7E57);
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h7E); send_byte(8'h57);
    send_byte(8'h29);
    byte_valid = 1'b0;
    check("f7_done",  32'(done),      32'd1);
    check("f7_hold",  32'(cpu_hold),  32'd0);
    check("f7_words", 32'(words),     32'd1);
    check("f7_addr",  32'(imem_addr), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_imem_loader
